// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address-width helper for the register file
// Purpose: default WIDTH/DEPTH/BYPASS values and the AW derivation used by every
//          file of the register-file slice.
// Ports:   none (package).
package regfile_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int BYPASS_DEF = 1;

  // Address width for a power-of-two register count (DEPTH >= 2).
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - read/write/reserve bus between a pipeline and the register file
// Purpose: bundles the two read ports, the write port, the reserve port and the
//          scoreboard status outputs.
// Ports:   master drives addresses, write data and strobes and receives read data
//          and pending status; slave is the register file.
interface regfile_if #(
  parameter int WIDTH = regfile_pkg::WIDTH_DEF,
  parameter int DEPTH = regfile_pkg::DEPTH_DEF
);
  import regfile_pkg::*;

  localparam int AW = addr_width(DEPTH);

  logic [AW-1:0]    ReadRegister1;
  logic [AW-1:0]    ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic [AW-1:0]    WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic             RegWrite;
  logic [AW-1:0]    ReserveRegister;
  logic             Reserve;
  logic             Pending1;
  logic             Pending2;
  logic             Stall;
  logic [AW:0]      PendingCount;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
           ReserveRegister, Reserve,
    input  ReadData1, ReadData2, Pending1, Pending2, Stall, PendingCount
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
           ReserveRegister, Reserve,
    output ReadData1, ReadData2, Pending1, Pending2, Stall, PendingCount
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits and registered pending count
// Purpose: tracks registers reserved by outstanding multi-cycle producers.
// Ports:   Clk, Reset_n (async active-low); set_en/set_addr reserve a register;
//          clr_en/clr_addr clear it on write; rd_addr1/2 with fwd1/2 (write being
//          forwarded to that read port) produce pending1/2; pending_count is the
//          registered number of pending registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int BYPASS = BYPASS_DEF,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  input  logic          fwd1,
  input  logic          fwd2,
  output logic          pending1,
  output logic          pending2,
  output logic [AW:0]   pending_count
);

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_next;
  logic             inc;
  logic             dec;
  logic             same_addr;

  // set_en/clr_en arrive already qualified with a nonzero address, so bit 0
  // is never set.
  assign same_addr = set_en && clr_en && (set_addr == clr_addr);

  // The count moves only on real transitions of a bit: re-reserving a pending
  // register or writing a non-pending one leaves it alone, and a reserve
  // overrides a clear of the same register.
  assign inc = set_en && !pend[set_addr];
  assign dec = clr_en && pend[clr_addr] && !same_addr;

  always_comb begin
    pend_next = pend;
    if (clr_en) pend_next[clr_addr] = 1'b0;
    if (set_en) pend_next[set_addr] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend          <= '0;
      pending_count <= '0;
    end else begin
      pend <= pend_next;
      if (inc && !dec)      pending_count <= pending_count + ONE;
      else if (dec && !inc) pending_count <= pending_count - ONE;
    end
  end

  // A forwarded write satisfies the reader this cycle unless the same register
  // is simultaneously re-reserved by a new producer.
  always_comb begin
    pending1 = pend[rd_addr1];
    pending2 = pend[rd_addr2];
    if (BYPASS != 0) begin
      if (fwd1 && !(set_en && set_addr == rd_addr1)) pending1 = 1'b0;
      if (fwd2 && !(set_en && set_addr == rd_addr2)) pending2 = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised 2-read/1-write register file with reservation scoreboard
// Purpose: storage with r0 hardwired to zero, combinational reads with optional
//          write-to-read forwarding, and a pending-write scoreboard.
// Ports:   Clk (posedge), Reset_n (async active-low), bus (regfile_if.slave).
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int BYPASS = BYPASS_DEF,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic     Clk,
  input  logic     Reset_n,
  regfile_if.slave bus
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             armed;
  logic             we;
  logic             rsv;
  logic             fwd1;
  logic             fwd2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  // armed stays low through reset and the first edge after release, so a
  // write or reserve coinciding with reset deassertion is dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  assign we  = bus.RegWrite && armed && (bus.WriteRegister != '0);
  assign rsv = bus.Reserve  && armed && (bus.ReserveRegister != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[bus.WriteRegister] <= bus.WriteData;
    end
  end

  assign fwd1 = (BYPASS != 0) && we && (bus.WriteRegister == bus.ReadRegister1);
  assign fwd2 = (BYPASS != 0) && we && (bus.WriteRegister == bus.ReadRegister2);

  always_comb begin
    rd1 = mem[bus.ReadRegister1];
    rd2 = mem[bus.ReadRegister2];
    if (fwd1) rd1 = bus.WriteData;
    if (fwd2) rd2 = bus.WriteData;
    if (bus.ReadRegister1 == '0) rd1 = '0;
    if (bus.ReadRegister2 == '0) rd2 = '0;
  end

  assign bus.ReadData1 = rd1;
  assign bus.ReadData2 = rd2;

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .set_en        (rsv),
    .set_addr      (bus.ReserveRegister),
    .clr_en        (we),
    .clr_addr      (bus.WriteRegister),
    .rd_addr1      (bus.ReadRegister1),
    .rd_addr2      (bus.ReadRegister2),
    .fwd1          (fwd1),
    .fwd2          (fwd2),
    .pending1      (bus.Pending1),
    .pending2      (bus.Pending2),
    .pending_count (bus.PendingCount)
  );

  assign bus.Stall = bus.Pending1 || bus.Pending2;

endmodule
